iris_fw_meta_streamer: RTL
==========================

Name: iris_fw_meta_streamer

Overview:
Next-generation FPGA FW metadata source. It generalises the static major/minor/patch constants into a parametrised, framed byte stream. On request, it serialises magic, length, version triple, a configurable-width build ID and a check byte over a valid/ready byte interface. It sits between the version constants and the camera telemetry/UART byte path, so ground can query the FW identity at run time.

Parameters:
FW_VER_MAJ, 11, major version byte (0..255; elaboration error if out of range)
FW_VER_MIN, 1, minor version byte (0..255)
FW_VER_PATCH, 1, patch byte (0..255)
BUILD_ID_BYTES, 4, build-ID width in bytes (1..16)
MAGIC, 8'hA5, frame start byte

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-high reset
req  in  1  one-cycle frame request pulse
build_id  in  8*BUILD_ID_BYTES  build identifier, MSB byte sent first
m_data  out  8  stream byte
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts byte when m_valid&&m_ready
m_last  out  1  high with final (check) byte
busy  out  1  frame in progress or request pending
frame_count  out  16  completed frames, wraps 0xFFFF->0x0000
major/minor/patch  out  8 each  static version, as before (combinational from params)

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst).
- Reset values: m_data=0, m_valid=0, m_last=0, busy=0, frame_count=0, pending=0, state=IDLE. Assertion mid-frame aborts immediately; no partial resume after release.
- Frame: byte0=MAGIC, byte1=LEN=3+BUILD_ID_BYTES, byte2=major, byte3=minor, byte4=patch, bytes 5..4+BUILD_ID_BYTES=build_id MSB first, final=CHK. Total = 6+BUILD_ID_BYTES bytes.
- CHK (default): 8-bit sum mod 256 of byte1 through the last build-ID byte; MAGIC is excluded.
- build_id is snapshotted on the cycle the frame starts. Later changes do not affect the frame in flight.
- FSM: IDLE -> SEND on req (or on pending). SEND walks a byte index 0..LEN+2. On acceptance of the final byte: frame_count++, then go to IDLE, or restart SEND directly if pending=1.
- Latency: req in cycle N while IDLE -> m_valid=1 with MAGIC registered in cycle N+1.
- Handshake: once m_valid rises, it stays high until the last byte is accepted, with no gaps. m_data/m_last are held stable while m_valid&&!m_ready. The index advances only on acceptance.
- Back-to-back: after the last-byte acceptance with pending=1, the next MAGIC is valid in the following cycle. pending clears at that restart.
- req while busy: sets pending (one deep). Further reqs while pending=1 are dropped. A req in the same cycle as the last-byte acceptance also sets pending.
- busy = (state!=IDLE) | pending.
- m_ready ignored while m_valid=0.

Optional Feature:
IRIS_FW_META_CRC8_EN
- Defined: CHK is CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, over the same byte range. MAGIC changes to 8'hA6 so the host can tell the check type.
- Undefined: additive checksum as above. Frame format and timing are identical in both cases.

Decomposition:
- Package iris_fw_meta_pkg: state enum {IDLE, SEND}, MAGIC defaults, CRC8 poly constant, frame-length function f(BUILD_ID_BYTES).
- Sub-module iris_fw_meta_chk: byte-wise check accumulator with clear/update inputs and 8-bit result. Sum or CRC8 is selected by the macro.

Test Plan:
- Defaults, build_id=0xDEADBEEF, m_ready=1, req pulse -> A5 07 0B 01 01 DE AD BE EF 4C over 10 consecutive cycles starting at N+1; m_last only on 4C; frame_count=1.
- Same frame with m_ready toggled pseudo-randomly -> identical byte sequence; m_data held stable during stalls; m_valid never drops mid-frame.
- Three reqs during one frame -> exactly two frames total, second MAGIC the cycle after first CHK accepted; frame_count=2.
- build_id changed to 0x01020304 after MAGIC accepted -> frame still carries DE AD BE EF, CHK 4C.
- rst asserted at byte 5 -> all outputs 0 asynchronously; after release, a req yields a full fresh frame starting with A5.
- IRIS_FW_META_CRC8_EN defined, BUILD_ID_BYTES=1, build_id=0x00 -> frame A6 04 0B 01 01 00 CRC; CRC matches the golden-model CRC-8/0x07 over 04 0B 01 01 00; frame_count wraps 0xFFFF->0x0000 after forced preload.

Source files
------------

// File: rtl/iris_fw_meta_pkg.sv
// Shared types and helpers for the FW metadata streamer.
// The IRIS_FW_META_CRC8_EN macro selects the CRC-8 check byte and the matching frame magic.
package iris_fw_meta_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

   localparam logic [7:0] MAGIC_SUM = 8'hA5;
   localparam logic [7:0] MAGIC_CRC = 8'hA6;
   localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef IRIS_FW_META_CRC8_EN
   localparam logic [7:0] MAGIC_DEFAULT = MAGIC_CRC;
`else
   localparam logic [7:0] MAGIC_DEFAULT = MAGIC_SUM;
`endif

   // Total bytes on the wire: magic, length, three version bytes, build ID, check.
   function automatic int frame_len(input int id_bytes);
      return 6 + id_bytes;
   endfunction

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
      logic [7:0] c;
      c = crc ^ din;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/iris_fw_meta_chk.sv
// Byte-wise check accumulator: additive sum by default, CRC-8/0x07 with IRIS_FW_META_CRC8_EN.
// next_o is the value the accumulator takes if din is folded in this cycle.
module iris_fw_meta_chk
   import iris_fw_meta_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       update,
   input  logic [7:0] din,
   output logic [7:0] next_o
);

   logic [7:0] acc_q;
   logic [7:0] acc_d;

   always_comb begin
`ifdef IRIS_FW_META_CRC8_EN
      next_o = crc8_step(acc_q, din);
`else
      next_o = acc_q + din;
`endif
      acc_d = acc_q;
      if (clear) begin
         acc_d = 8'h00;
      end else if (update) begin
         acc_d = next_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= 8'h00;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/iris_fw_meta_streamer.sv
// Framed FW identity byte stream over a valid/ready interface.
// Check type and magic follow the IRIS_FW_META_CRC8_EN macro (see iris_fw_meta_pkg).
module iris_fw_meta_streamer
   import iris_fw_meta_pkg::*;
#(
   parameter int         FW_VER_MAJ     = 11,
   parameter int         FW_VER_MIN     = 1,
   parameter int         FW_VER_PATCH   = 1,
   parameter int         BUILD_ID_BYTES = 4,
   parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req,
   input  logic [8*BUILD_ID_BYTES-1:0] build_id,
   output logic [7:0]                  m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        m_last,
   output logic                        busy,
   output logic [15:0]                 frame_count,
   output logic [7:0]                  major,
   output logic [7:0]                  minor,
   output logic [7:0]                  patch
);

   localparam int ID_W     = 8 * BUILD_ID_BYTES;
   localparam int LEN      = 3 + BUILD_ID_BYTES;
   localparam int LAST_IDX = frame_len(BUILD_ID_BYTES) - 1;
   localparam int IDX_W    = $clog2(frame_len(BUILD_ID_BYTES));

   if (FW_VER_MAJ < 0 || FW_VER_MAJ > 255) begin : g_bad_maj
      $error("FW_VER_MAJ out of range 0..255");
   end
   if (FW_VER_MIN < 0 || FW_VER_MIN > 255) begin : g_bad_min
      $error("FW_VER_MIN out of range 0..255");
   end
   if (FW_VER_PATCH < 0 || FW_VER_PATCH > 255) begin : g_bad_patch
      $error("FW_VER_PATCH out of range 0..255");
   end
   if (BUILD_ID_BYTES < 1 || BUILD_ID_BYTES > 16) begin : g_bad_bid
      $error("BUILD_ID_BYTES out of range 1..16");
   end

   assign major = 8'(FW_VER_MAJ);
   assign minor = 8'(FW_VER_MIN);
   assign patch = 8'(FW_VER_PATCH);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
   logic [ID_W-1:0]  bid_q, bid_d;
   logic             pending_q, pending_d;
   logic [15:0]      frame_count_q, frame_count_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             m_last_q, m_last_d;
   logic             accept, start, chk_clear, chk_update;
   logic [7:0]       chk_next;

   // Payload byte at a given frame position; the check byte is supplied separately.
   function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                             input logic [ID_W-1:0]  bid);
      int k;
      k = BUILD_ID_BYTES - 1 - (int'(idx) - 5);
      if (int'(idx) == 0)      return MAGIC;
      else if (int'(idx) == 1) return 8'(LEN);
      else if (int'(idx) == 2) return major;
      else if (int'(idx) == 3) return minor;
      else if (int'(idx) == 4) return patch;
      else if (k >= 0 && k < BUILD_ID_BYTES) return 8'(bid >> (8 * k));
      else                     return 8'h00;
   endfunction

   iris_fw_meta_chk u_chk (
      .clk    (clk),
      .rst    (rst),
      .clear  (chk_clear),
      .update (chk_update),
      .din    (m_data_q),
      .next_o (chk_next)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      idx_nxt       = idx_q + 1'b1;
      bid_d         = bid_q;
      pending_d     = pending_q;
      frame_count_d = frame_count_q;
      m_data_d      = m_data_q;
      m_valid_d     = m_valid_q;
      m_last_d      = m_last_q;
      chk_clear     = 1'b0;
      chk_update    = 1'b0;
      start         = 1'b0;
      accept        = m_valid_q && m_ready;
      case (state_q)
         IDLE: begin
            if (req || pending_q) begin
               start     = 1'b1;
               pending_d = 1'b0;
            end
         end
         SEND: begin
            if (req) pending_d = 1'b1;
            if (accept) begin
               if (m_last_q) begin
                  frame_count_d = frame_count_q + 16'd1;
                  if (pending_q) begin
                     start     = 1'b1;
                     pending_d = req;
                  end else begin
                     state_d   = IDLE;
                     m_valid_d = 1'b0;
                     m_last_d  = 1'b0;
                     m_data_d  = 8'h00;
                  end
               end else begin
                  // MAGIC (index 0) is excluded from the check.
                  chk_update = (idx_q != '0);
                  idx_d      = idx_nxt;
                  if (idx_nxt == IDX_W'(LAST_IDX)) begin
                     m_data_d = chk_next;
                     m_last_d = 1'b1;
                  end else begin
                     m_data_d = frame_byte(idx_nxt, bid_q);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d   = SEND;
         idx_d     = '0;
         bid_d     = build_id;
         m_data_d  = MAGIC;
         m_valid_d = 1'b1;
         m_last_d  = 1'b0;
         chk_clear = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         bid_q         <= '0;
         pending_q     <= 1'b0;
         frame_count_q <= 16'h0000;
         m_data_q      <= 8'h00;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         bid_q         <= bid_d;
         pending_q     <= pending_d;
         frame_count_q <= frame_count_d;
         m_data_q      <= m_data_d;
         m_valid_q     <= m_valid_d;
         m_last_q      <= m_last_d;
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign busy        = (state_q != IDLE) | pending_q;
   assign frame_count = frame_count_q;

endmodule
